// File: rtl/uart_tx_fifo.sv
// Byte FIFO sitting in front of a UART transmitter. The core pushes bytes with
// wr_en; whenever the transmitter reports sendable and a byte is queued, one byte
// is issued with a single-cycle order strobe and held on write_data.
module uart_tx_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned LOG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_en,
  input  logic [7:0]           wr_data,
  input  logic                 clear,
  output logic                 full,
  output logic [LOG_DEPTH:0]   count,
  output logic                 overflow,
  output logic                 order,
  output logic [7:0]           write_data,
  input  logic                 sendable
);

  localparam logic [LOG_DEPTH:0]   FullCount = (LOG_DEPTH + 1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   CntOne    = (LOG_DEPTH + 1)'(1);
  localparam logic [LOG_DEPTH-1:0] PtrOne    = LOG_DEPTH'(1);

  logic [7:0]           mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 order_q, order_d;
  logic [7:0]           write_data_q, write_data_d;

  logic full_w;
  logic empty_w;
  logic push;
  logic pop;

  // Flags come from the registered count, so they reflect the state before the edge.
  always_comb begin
    full_w  = (count_q == FullCount);
    empty_w = (count_q == '0);
    push    = wr_en && !full_w && !clear;
    // order_q gate keeps the strobe from ever lasting two cycles.
    pop     = sendable && !empty_w && !order_q && !clear;
  end

  // Next-state for pointers, occupancy, sticky overflow and the issue strobe.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    order_d      = 1'b0;
    write_data_d = write_data_q;

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (wr_en && full_w) begin
        overflow_d = 1'b1;
      end
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + PtrOne;
        order_d      = 1'b1;
        write_data_d = mem_q[rd_ptr_q];
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state, cleared asynchronously; an in-flight order is abandoned on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      order_q      <= 1'b0;
      write_data_q <= 8'h00;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      order_q      <= order_d;
      write_data_q <= write_data_d;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Outputs straight from registers.
  always_comb begin
    full       = full_w;
    count      = count_q;
    overflow   = overflow_q;
    order      = order_q;
    write_data = write_data_q;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH     = 16;
  localparam int LOG_DEPTH = 4;

  logic                clk;
  logic                rstn;
  logic                wr_en;
  logic [7:0]          wr_data;
  logic                clear;
  logic                full;
  logic [LOG_DEPTH:0]  count;
  logic                overflow;
  logic                order;
  logic [7:0]          write_data;
  logic                sendable;

  uart_tx_fifo #(
    .DEPTH    (DEPTH),
    .LOG_DEPTH(LOG_DEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clear     (clear),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .order     (order),
    .write_data(write_data),
    .sendable  (sendable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of bytes plus the visible flags.
  logic [7:0] mq[$];
  logic       m_ovf;
  logic       m_ord;
  logic [7:0] m_wd;
  logic       prev_order;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       clr;
    logic       snd;
    int         cnt;
    logic       ord;
    logic [7:0] wd;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf      = 1'b0;
    m_ord      = 1'b0;
    m_wd       = 8'h00;
    prev_order = 1'b0;
  endtask

  // Advance the model by one edge using the currently applied inputs.
  task automatic model_edge();
    bit was_full;
    bit do_pop;
    was_full = (mq.size() == DEPTH);
    if (clear) begin
      mq.delete();
      m_ovf = 1'b0;
      m_ord = 1'b0;
    end else begin
      do_pop = sendable && (mq.size() != 0) && !m_ord;
      if (do_pop) m_wd = mq.pop_front();
      m_ord = do_pop;
      if (wr_en) begin
        if (was_full) m_ovf = 1'b1;
        else mq.push_back(wr_data);
      end
    end
  endtask

  task automatic compare_model();
    chk("count", int'(count), mq.size());
    chk("full", int'(full), int'(mq.size() == DEPTH));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("order", int'(order), int'(m_ord));
    chk("write_data", int'(write_data), int'(m_wd));
    checks++;
    if (prev_order && order) begin
      errors++;
      $display("FAIL order_pulse: got two-cycle order, expected single cycle at %0t", $time);
    end
    prev_order = order;
  endtask

  // One clock: model update, edge, sample 1ns later, compare.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic set_in(input logic w, input logic [7:0] d, input logic c, input logic s);
    wr_en    = w;
    wr_data  = d;
    clear    = c;
    sendable = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Directed vectors: single byte latency, push+pop, strobe spacing, clear.
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 8'hA5, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'hA5, 1'b0};
    vecs[3] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1, 1'b0, 8'hA5, 1'b0};
    vecs[4] = '{1'b1, 8'hC3, 1'b0, 1'b1, 1, 1'b1, 8'h3C, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 8'h3C, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 8'hC3, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'hC3, 1'b0};
    vecs[8] = '{1'b1, 8'h11, 1'b1, 1'b1, 0, 1'b0, 8'hC3, 1'b0};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'hC3, 1'b0};

    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    rstn = 1'b0;
    model_reset();
    #2;
    chk("reset_count", int'(count), 0);
    chk("reset_full", int'(full), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_order", int'(order), 0);
    chk("reset_write_data", int'(write_data), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].wr, vecs[i].d, vecs[i].clr, vecs[i].snd);
      tick();
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
      chk($sformatf("vec%0d_order", i), int'(order), int'(vecs[i].ord));
      chk($sformatf("vec%0d_wdata", i), int'(write_data), int'(vecs[i].wd));
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].ovf));
    end

    // Fill to full, overflow, then drain one pulse at a time.
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 8'(i), 1'b0, 1'b0);
      tick();
    end
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 16);
    set_in(1'b1, 8'hFF, 1'b0, 1'b0);
    tick();
    chk("fill_overflow", int'(overflow), 1);
    chk("fill_count_hold", int'(count), 16);
    for (int i = 0; i < 16; i++) begin
      set_in(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      chk("drain_order", int'(order), 1);
      chk("drain_byte", int'(write_data), i);
      set_in(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
    end
    chk("drain_empty", int'(count), 0);
    chk("drain_ovf_sticky", int'(overflow), 1);
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    chk("clear_ovf", int'(overflow), 0);

    // Simultaneous push and pop at count 5.
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 8'h55, 1'b0, 1'b1);
    tick();
    chk("pushpop_count", int'(count), 5);
    chk("pushpop_order", int'(order), 1);
    chk("pushpop_byte", int'(write_data), 8'h50);
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    tick();

    // Clear at count 7 with push and send requested.
    for (int i = 0; i < 7; i++) begin
      set_in(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 8'hEE, 1'b1, 1'b1);
    tick();
    chk("clear_count", int'(count), 0);
    chk("clear_order", int'(order), 0);
    chk("clear_overflow", int'(overflow), 0);
    set_in(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (3) begin
      tick();
      chk("clear_no_issue", int'(order), 0);
    end

    // Randomized traffic with sendable gaps and rare clears.
    begin
      int pushes;
      pushes = 0;
      for (int c = 0; c < 600; c++) begin
        set_in(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 99) == 0),
               ($urandom_range(0, 2) != 0));
        if (wr_en) pushes++;
        tick();
      end
      set_in(1'b0, 8'h00, 1'b0, 1'b1);
      repeat (40) tick();
      chk("random_drained", int'(count), 0);
      checks++;
      if (pushes < 40) begin
        errors++;
        $display("FAIL random_pushes: got %0d, expected at least 40", pushes);
      end
    end

    // Asynchronous reset while an order is in flight.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("pre_reset_order", int'(order), 1);
    chk("pre_reset_count", int'(count), 3);
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_reset_order", int'(order), 0);
    chk("async_reset_count", int'(count), 0);
    chk("async_reset_full", int'(full), 0);
    chk("async_reset_wdata", int'(write_data), 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    set_in(1'b1, 8'h99, 1'b0, 1'b0);
    tick();
    chk("first_push_after_reset", int'(count), 1);
    set_in(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("first_push_issued", int'(write_data), 8'h99);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
